// File: rtl/rf_stack_banked_pkg.sv
// Shared constants and types for the banked interrupt-level register file.
// Imported by the interface, the copy engine and the top.
package rf_stack_banked_pkg;

  localparam int unsigned ZeroReg      = 0;
  localparam int unsigned RaReg        = 1;
  localparam int unsigned SpReg        = 2;
  localparam int unsigned MaxDataWidth = 64;

  // Truncated to DataWidth at the point of use.
  localparam logic [MaxDataWidth-1:0] RaMarker = '1;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } rf_copy_state_e;

endpackage

// File: rtl/rf_stack_banked_if.sv
// Core-side bus of the banked register file: core read/write port,
// level-entry push handshake and the copy-engine debug state.
interface rf_stack_banked_if
  import rf_stack_banked_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int NumRegs      = 32,
  parameter int NumLevels    = 8,
  parameter int NumReadPorts = 2
);
  localparam int RegW   = $clog2(NumRegs);
  localparam int LevelW = $clog2(NumLevels);

  logic [LevelW-1:0]                 level;
  logic                              write_en;
  logic [RegW-1:0]                   write_addr;
  logic [DataWidth-1:0]              write_data;
  logic [NumReadPorts*RegW-1:0]      read_addr;
  logic [NumReadPorts*DataWidth-1:0] read_data;

  // A push is accepted in the cycle where push_valid && push_ready; push_ready
  // is simply !busy, so the requester may hold push_valid until it is taken.
  logic                              push_valid;
  logic                              push_ready;
  logic [LevelW-1:0]                 push_src;
  logic [LevelW-1:0]                 push_dst;
  logic                              busy;
  rf_copy_state_e                    copy_state;

  modport master (
    output level, write_en, write_addr, write_data, read_addr,
    output push_valid, push_src, push_dst,
    input  read_data, push_ready, busy, copy_state
  );

  modport slave (
    input  level, write_en, write_addr, write_data, read_addr,
    input  push_valid, push_src, push_dst,
    output read_data, push_ready, busy, copy_state
  );

endinterface

// File: rtl/rf_stack_banked_copy_fsm.sv
// Push-time argument copy engine: latches src/dst on an accepted push and
// walks CopyBase..CopyBase+CopyCount-1, one register per cycle.
module rf_stack_banked_copy_fsm
  import rf_stack_banked_pkg::*;
#(
  parameter int                 NumRegs    = 32,
  parameter int                 NumLevels  = 8,
  parameter logic [NumRegs-1:0] SharedMask = 'h4,
  parameter int                 CopyBase   = 10,
  parameter int                 CopyCount  = 8,
  localparam int                RegW       = $clog2(NumRegs),
  localparam int                LevelW     = $clog2(NumLevels)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [LevelW-1:0] push_src,
  input  logic [LevelW-1:0] push_dst,
  output logic              push_ready,
  output logic              push_fire,
  output logic              busy,
  output logic              copy_we,
  output logic [RegW-1:0]   copy_addr,
  output logic [LevelW-1:0] copy_src,
  output logic [LevelW-1:0] copy_dst,
  output rf_copy_state_e    state
);

  localparam int CntW    = (CopyCount > 1) ? $clog2(CopyCount) : 1;
  localparam int LastIdx = (CopyCount > 0) ? CopyCount - 1 : 0;

  rf_copy_state_e    state_q, state_d;
  logic [CntW-1:0]   idx_q, idx_d;
  logic [LevelW-1:0] src_q, src_d;
  logic [LevelW-1:0] dst_q, dst_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign copy_addr = RegW'(CopyBase) + RegW'(idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
    push_ready = 1'b0;
    push_fire  = 1'b0;
    busy       = 1'b0;
    copy_we    = 1'b0;
    case (state_q)
      IDLE: begin
        push_ready = 1'b1;
        push_fire  = push_valid;
        if (push_valid) begin
          src_d = push_src;
          dst_d = push_dst;
          if (CopyCount > 0) begin
            state_d = COPY;
            idx_d   = '0;
          end
        end
      end
      COPY: begin
        busy = 1'b1;
        // Shared and x0 slots still burn their cycle so latency is fixed.
        copy_we = !SharedMask[copy_addr] && (copy_addr != RegW'(ZeroReg));
        idx_d   = idx_q + 1'b1;
        if (idx_q == CntW'(LastIdx)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign copy_src = src_q;
  assign copy_dst = dst_q;
  assign state    = state_q;

endmodule

// File: rtl/rf_stack_banked.sv
// Banked interrupt-level register file: one bank per priority level, shared
// registers pinned to bank 0, combinational read ports with write bypass.
module rf_stack_banked
  import rf_stack_banked_pkg::*;
#(
  parameter int                 DataWidth    = 32,
  parameter int                 NumRegs      = 32,
  parameter int                 NumLevels    = 8,
  parameter int                 NumReadPorts = 2,
  parameter logic [NumRegs-1:0] SharedMask   = 'h4,
  parameter int                 CopyBase     = 10,
  parameter int                 CopyCount    = 8
) (
  input logic               clk,
  input logic               reset,
  rf_stack_banked_if.slave  rf
);

  localparam int RegW   = $clog2(NumRegs);
  localparam int LevelW = $clog2(NumLevels);

  if (NumLevels < 2) begin : g_bad_levels
    $error("rf_stack_banked: NumLevels must be at least 2");
  end
  if (NumReadPorts < 1) begin : g_bad_ports
    $error("rf_stack_banked: NumReadPorts must be at least 1");
  end
  if (CopyBase + CopyCount > NumRegs) begin : g_bad_copy
    $error("rf_stack_banked: copy range overruns the register bank");
  end

  function automatic logic [LevelW-1:0] bank_of(input logic [RegW-1:0]   r,
                                                input logic [LevelW-1:0] l);
    return SharedMask[r] ? '0 : l;
  endfunction

  logic [DataWidth-1:0] regs [NumLevels][NumRegs];

  logic              push_fire;
  logic              busy;
  logic              copy_we;
  logic [RegW-1:0]   copy_addr;
  logic [LevelW-1:0] copy_src;
  logic [LevelW-1:0] copy_dst;
  logic              core_we;
  logic              marker_we;
  logic [LevelW-1:0] core_bank;

  rf_stack_banked_copy_fsm #(
    .NumRegs    (NumRegs),
    .NumLevels  (NumLevels),
    .SharedMask (SharedMask),
    .CopyBase   (CopyBase),
    .CopyCount  (CopyCount)
  ) u_copy_fsm (
    .clk        (clk),
    .reset      (reset),
    .push_valid (rf.push_valid),
    .push_src   (rf.push_src),
    .push_dst   (rf.push_dst),
    .push_ready (rf.push_ready),
    .push_fire  (push_fire),
    .busy       (busy),
    .copy_we    (copy_we),
    .copy_addr  (copy_addr),
    .copy_src   (copy_src),
    .copy_dst   (copy_dst),
    .state      (rf.copy_state)
  );

  assign rf.busy   = busy;
  assign core_we   = rf.write_en && (rf.write_addr != '0) && !busy;
  assign core_bank = bank_of(rf.write_addr, rf.level);
  assign marker_we = push_fire && !SharedMask[RaReg];

  // Later assignments win: the core write overrides the ra marker when both
  // land on the same bank and register in the handshake cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < NumLevels; l++) begin
        for (int r = 0; r < NumRegs; r++) begin
          regs[l][r] <= '0;
        end
      end
    end else begin
      if (copy_we) begin
        regs[copy_dst][copy_addr] <= regs[copy_src][copy_addr];
      end
      if (marker_we) begin
        regs[rf.push_dst][RegW'(RaReg)] <= DataWidth'(RaMarker);
      end
      if (core_we) begin
        regs[core_bank][rf.write_addr] <= rf.write_data;
      end
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [RegW-1:0]      addr;
    logic [DataWidth-1:0] data;

    assign addr = rf.read_addr[p*RegW +: RegW];

    always_comb begin
      data = '0;
      if (addr == '0) begin
        data = '0;
      end else if (core_we && (addr == rf.write_addr)) begin
        data = rf.write_data;
      end else begin
        data = regs[bank_of(addr, rf.level)][addr];
      end
    end

    assign rf.read_data[p*DataWidth +: DataWidth] = data;
  end

  // The core must stall on busy; a write offered during a copy is discarded.
  write_during_busy: assert property (
    @(posedge clk) disable iff (reset) !(rf.write_en && busy)
  ) else $warning("rf_stack_banked: write_en asserted while busy, write dropped");

endmodule
